io_port_bank: RTL
=================

Name: io_port_bank

Overview:
- Parametrised successor to the single-register in/out ports on the CPU bus.
- Provides NUM_CH input channels and NUM_CH output channels, each buffered by a FIFO with a valid/ready handshake on the external side.
- CPU side is a bus-attached register interface driven by control-unit strobes (port_read, port_write), with a channel index taken from the instruction.
- Adds per-channel buffering, backpressure, sticky error flags and a status word, none of which the single-register ports have.

Parameters:
- DATA_W, 32, width of bus and channel data.
- NUM_CH, 2, number of input and of output channels (1..8).
- FIFO_DEPTH, 4, entries per FIFO; power of two, 2..16.

Ports:
- clk  in  1  system clock, rising edge.
- clr  in  1  reset, synchronous, active-high.
- bus_in  in  DATA_W  CPU bus value, written to the selected output FIFO.
- port_sel  in  3  channel index; values >= NUM_CH are invalid.
- port_write  in  1  push bus_in into output FIFO[port_sel].
- port_read  in  1  pop input FIFO[port_sel] into rd_data.
- err_clr  in  1  clears all sticky error flags.
- rd_data  out  DATA_W  registered read result, driven onto the bus by InPortout.
- status  out  32  {sel_err, rd_underflow, wr_overflow, 5'b0, out_full[7:0], in_nonempty[7:0], 8'b0}; unused channel bits are 0.
- in_valid  in  NUM_CH  external producer valid, per channel.
- in_data  in  NUM_CH*DATA_W  external producer data; channel k occupies [k*DATA_W +: DATA_W].
- in_ready  out  NUM_CH  input FIFO k not full.
- out_valid  out  NUM_CH  output FIFO k not empty.
- out_data  out  NUM_CH*DATA_W  head of output FIFO k, same packing as in_data.
- out_ready  in  NUM_CH  external consumer ready, per channel.

Behaviour:
- Reset (clr=1 at a clk edge) empties all FIFOs, sets rd_data=0, clears all error flags. After reset: in_ready all 1, out_valid all 0, status=0. Reset wins over every simultaneous event, including a push or pop in flight.
- Input push: on a clk edge with in_valid[k] & in_ready[k], in_data[k] is written. in_ready[k] = !full[k] only; it does not look ahead to a same-cycle pop.
- port_read, valid sel, FIFO non-empty: pops the head; rd_data holds it from the next edge (1-cycle latency) until the next successful read.
- port_read on an empty FIFO: no pop, rd_data unchanged, rd_underflow set (sticky).
- External push and port_read on the same channel, same cycle: both take effect; occupancy unchanged.
- port_write, valid sel, FIFO not full: bus_in is pushed.
- port_write on a full FIFO: pushed only if out_valid & out_ready pops that same channel in the same cycle. Otherwise data is dropped and wr_overflow is set.
- Output drain: out_data[k] is the combinational head of FIFO k; pop on out_valid[k] & out_ready[k].
- port_sel >= NUM_CH with port_read or port_write: no state change except sel_err set (sticky); rd_data unchanged.
- port_read and port_write may be asserted together. They act on different FIFOs, so both proceed.
- err_clr clears all flags; an error event in the same cycle wins (flag ends set).
- Pointers wrap modulo FIFO_DEPTH. Occupancy counter is clog2(FIFO_DEPTH)+1 bits; full when count == FIFO_DEPTH.
- FIFO storage needs no reset.

Decomposition:
- Shared header io_defs.vh holds:
  - status bit positions (STAT_SEL_ERR=31, STAT_RD_UF=30, STAT_WR_OF=29, STAT_OUT_FULL_LSB=16, STAT_IN_NE_LSB=8);
  - MAX_CH=8.
- Sub-module sync_fifo (params W, DEPTH; ports clk, clr, push, pop, din, dout, full, empty, count), instantiated 2*NUM_CH times via generate.
- Top level holds only the select/decode logic, rd_data, the error flags and status packing.

Test Plan:
- Reset: assert clr one cycle -> rd_data=0, status=0, in_ready=2'b11, out_valid=2'b00.
- Input FIFO ordering: push 0x11,0x22,0x33,0x44 on ch1 -> in_ready[1]=0 after the 4th; status[9]=1. Four port_reads with sel=1 -> rd_data 0x11,0x22,0x33,0x44, each one cycle after its strobe. A 5th read -> rd_data stays 0x44, status[30]=1.
- Output drain: port_write 0xDEADBEEF, 0x5 to ch0 with out_ready=0 -> out_valid[0]=1, out_data[0]=0xDEADBEEF. Raise out_ready -> 0xDEADBEEF then 0x5 delivered on consecutive cycles, then out_valid[0]=0.
- Overflow vs concurrent drain: fill ch0 output (4 entries), out_ready=0, write 0x99 -> dropped, status[29]=1. Refill to full, write 0x77 with out_ready=1 that cycle -> accepted, count stays 4, 0x77 appears last, no new error.
- Select error and flag clear: port_sel=5 with port_write -> sel_err=1, no FIFO change. Pulse err_clr -> status[31:29]=0. err_clr together with an underflow read -> rd_underflow remains 1.
- Reset mid-operation: ch0 in-FIFO holds 3 entries, clr asserted together with port_read -> FIFO empty, rd_data=0, no error flag set.

Source files
------------

// File: rtl/io_port_bank_pkg.sv
// Shared constants, error-flag payload and status packing for the I/O port bank.
package io_port_bank_pkg;

  localparam int unsigned MAX_CH            = 8;
  localparam int unsigned SEL_W             = 3;
  localparam int unsigned STATUS_W          = 32;
  localparam int unsigned STAT_SEL_ERR      = 31;
  localparam int unsigned STAT_RD_UF        = 30;
  localparam int unsigned STAT_WR_OF        = 29;
  localparam int unsigned STAT_OUT_FULL_LSB = 16;
  localparam int unsigned STAT_IN_NE_LSB    = 8;

  typedef struct packed {
    logic sel_err;
    logic rd_uf;
    logic wr_of;
  } err_flags_t;

  // Places the sticky flags and per-channel levels at their status bit positions.
  function automatic logic [STATUS_W-1:0] pack_status(
    input err_flags_t        flags,
    input logic [MAX_CH-1:0] out_full,
    input logic [MAX_CH-1:0] in_ne
  );
    logic [STATUS_W-1:0] s;
    s                                  = '0;
    s[STAT_SEL_ERR]                    = flags.sel_err;
    s[STAT_RD_UF]                      = flags.rd_uf;
    s[STAT_WR_OF]                      = flags.wr_of;
    s[STAT_OUT_FULL_LSB +: MAX_CH]     = out_full;
    s[STAT_IN_NE_LSB +: MAX_CH]        = in_ne;
    return s;
  endfunction

endpackage

// File: rtl/io_port_bank_if.sv
// CPU register strobes plus the per-channel valid/ready streams of the port bank.
interface io_port_bank_if #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned NUM_CH = 2
);
  import io_port_bank_pkg::*;

  logic [DATA_W-1:0]        bus_in;
  logic [SEL_W-1:0]         port_sel;
  logic                     port_write;
  logic                     port_read;
  logic                     err_clr;
  logic [DATA_W-1:0]        rd_data;
  logic [STATUS_W-1:0]      status;
  logic [NUM_CH-1:0]        in_valid;
  logic [NUM_CH*DATA_W-1:0] in_data;
  logic [NUM_CH-1:0]        in_ready;
  logic [NUM_CH-1:0]        out_valid;
  logic [NUM_CH*DATA_W-1:0] out_data;
  logic [NUM_CH-1:0]        out_ready;

  modport slave (
    input  bus_in, port_sel, port_write, port_read, err_clr,
    input  in_valid, in_data, out_ready,
    output rd_data, status, in_ready, out_valid, out_data
  );

  modport master (
    output bus_in, port_sel, port_write, port_read, err_clr,
    output in_valid, in_data, out_ready,
    input  rd_data, status, in_ready, out_valid, out_data
  );

endinterface

// File: rtl/io_port_bank_sync_fifo.sv
// Single-clock FIFO; push on a full FIFO is honoured only alongside a pop.
module io_port_bank_sync_fifo #(
  parameter int unsigned W     = 32,
  parameter int unsigned DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       clr,
  input  logic                       push,
  input  logic                       pop,
  input  logic [W-1:0]               din,
  output logic [W-1:0]               dout,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH):0]     count
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  logic [W-1:0]  mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          push_ok;
  logic          pop_ok;

  always_comb begin
    full     = (count_q == CW'(DEPTH));
    empty    = (count_q == '0);
    pop_ok   = pop && !empty;
    push_ok  = push && (!full || pop_ok);
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    // Power-of-two depth lets the pointers wrap by natural overflow.
    if (push_ok) wr_ptr_d = wr_ptr_q + AW'(1);
    if (pop_ok)  rd_ptr_d = rd_ptr_q + AW'(1);
    if (push_ok && !pop_ok)      count_d = count_q + CW'(1);
    else if (pop_ok && !push_ok) count_d = count_q - CW'(1);
  end

  always_ff @(posedge clk) begin
    if (clr) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage carries no reset; occupancy alone defines what is valid.
  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wr_ptr_q] <= din;
  end

  assign dout  = mem_q[rd_ptr_q];
  assign count = count_q;

endmodule

// File: rtl/io_port_bank.sv
// Bank of NUM_CH input and NUM_CH output FIFOs behind CPU port_read/port_write strobes.
module io_port_bank
  import io_port_bank_pkg::*;
#(
  parameter int unsigned DATA_W     = 32,
  parameter int unsigned NUM_CH     = 2,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic             clk,
  input  logic             clr,
  io_port_bank_if.slave    bus
);

  localparam int unsigned CNT_W = $clog2(FIFO_DEPTH) + 1;

  logic [NUM_CH-1:0]        in_push, in_pop, in_full, in_empty;
  logic [NUM_CH-1:0]        out_push, out_pop, out_full, out_empty;
  logic [NUM_CH-1:0]        rd_hit, wr_hit;
  logic [DATA_W-1:0]        in_dout  [NUM_CH];
  logic [DATA_W-1:0]        out_dout [NUM_CH];
  logic [CNT_W-1:0]         in_cnt   [NUM_CH];
  logic [CNT_W-1:0]         out_cnt  [NUM_CH];
  logic [NUM_CH*DATA_W-1:0] out_data_c;
  logic [MAX_CH-1:0]        in_ne_c, out_lvl_full_c;
  logic                     sel_ok;
  logic                     uf_ev, of_ev, sel_ev;
  logic [DATA_W-1:0]        rd_data_q, rd_data_d;
  err_flags_t               flags_q, flags_d;

  // Channel decode and per-FIFO push/pop qualification.
  always_comb begin
    sel_ok   = (32'(bus.port_sel) < NUM_CH);
    rd_hit   = '0;
    wr_hit   = '0;
    in_push  = '0;
    in_pop   = '0;
    out_push = '0;
    out_pop  = '0;
    for (int unsigned k = 0; k < NUM_CH; k++) begin
      rd_hit[k]   = bus.port_read  && sel_ok && (bus.port_sel == SEL_W'(k));
      wr_hit[k]   = bus.port_write && sel_ok && (bus.port_sel == SEL_W'(k));
      in_push[k]  = bus.in_valid[k] && !in_full[k];
      in_pop[k]   = rd_hit[k] && !in_empty[k];
      out_pop[k]  = !out_empty[k] && bus.out_ready[k];
      out_push[k] = wr_hit[k] && (!out_full[k] || out_pop[k]);
    end
  end

  for (genvar k = 0; k < NUM_CH; k++) begin : g_ch
    io_port_bank_sync_fifo #(.W(DATA_W), .DEPTH(FIFO_DEPTH)) u_in_fifo (
      .clk   (clk),
      .clr   (clr),
      .push  (in_push[k]),
      .pop   (in_pop[k]),
      .din   (bus.in_data[k*DATA_W +: DATA_W]),
      .dout  (in_dout[k]),
      .full  (in_full[k]),
      .empty (in_empty[k]),
      .count (in_cnt[k])
    );

    io_port_bank_sync_fifo #(.W(DATA_W), .DEPTH(FIFO_DEPTH)) u_out_fifo (
      .clk   (clk),
      .clr   (clr),
      .push  (out_push[k]),
      .pop   (out_pop[k]),
      .din   (bus.bus_in),
      .dout  (out_dout[k]),
      .full  (out_full[k]),
      .empty (out_empty[k]),
      .count (out_cnt[k])
    );
  end

  // Read result capture and sticky error flags; an event in the err_clr cycle survives.
  always_comb begin
    rd_data_d = rd_data_q;
    uf_ev     = 1'b0;
    of_ev     = 1'b0;
    sel_ev    = (bus.port_read || bus.port_write) && !sel_ok;
    for (int unsigned k = 0; k < NUM_CH; k++) begin
      if (in_pop[k]) rd_data_d = in_dout[k];
      uf_ev = uf_ev || (rd_hit[k] && in_empty[k]);
      of_ev = of_ev || (wr_hit[k] && out_full[k] && !out_pop[k]);
    end
    flags_d = bus.err_clr ? '0 : flags_q;
    if (sel_ev) flags_d.sel_err = 1'b1;
    if (uf_ev)  flags_d.rd_uf   = 1'b1;
    if (of_ev)  flags_d.wr_of   = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (clr) begin
      rd_data_q <= '0;
      flags_q   <= '0;
    end else begin
      rd_data_q <= rd_data_d;
      flags_q   <= flags_d;
    end
  end

  // Status levels and stream outputs, all derived from registered FIFO state.
  always_comb begin
    in_ne_c        = '0;
    out_lvl_full_c = '0;
    out_data_c     = '0;
    for (int unsigned k = 0; k < NUM_CH; k++) begin
      in_ne_c[k]                        = (in_cnt[k] != '0);
      out_lvl_full_c[k]                 = (out_cnt[k] == CNT_W'(FIFO_DEPTH));
      out_data_c[k*DATA_W +: DATA_W]    = out_dout[k];
    end
  end

  assign bus.rd_data   = rd_data_q;
  assign bus.status    = pack_status(flags_q, out_lvl_full_c, in_ne_c);
  assign bus.in_ready  = ~in_full;
  assign bus.out_valid = ~out_empty;
  assign bus.out_data  = out_data_c;

endmodule
